vis_framer: RTL and testbench

//  Bus-side packetiser directly downstream of the correlator's 8-bit AXI-S visibility output.

---
 rtl/vis_framer_if.sv | 25 ++
 rtl/vis_framer.sv | 210 +++++++++++++++++++++
 tb/tb_vis_framer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vis_framer_if.sv
// Single-lane 8-bit AXI-Stream bundle with tkeep, used on both sides of the framer.
// The master drives payload/valid, the slave returns tready.
interface vis_framer_if;
  logic       tvalid;
  logic       tready;
  logic       tkeep;
  logic       tlast;
  logic [7:0] tdata;

  modport master (
    output tvalid,
    output tkeep,
    output tlast,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tkeep,
    input  tlast,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/vis_framer.sv
// Host-link packetiser: sync, sequence, payload, byte count, flags and XOR checksum
// around each tlast-delimited correlator frame, with truncation at MAX_BYTES.
module vis_framer #(
  parameter logic [7:0]  SYNC0     = 8'h5A,
  parameter logic [7:0]  SYNC1     = 8'hA5,
  parameter int unsigned MAX_BYTES = 4096
) (
  input  logic         bus_clock,
  input  logic         areset_n,
  vis_framer_if.slave  s_axis,
  vis_framer_if.master m_axis,
  output logic [15:0]  seq_o,
  output logic         trunc_o
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC0,
    ST_SYNC1,
    ST_SEQLO,
    ST_SEQHI,
    ST_BODY,
    ST_CNTLO,
    ST_CNTHI,
    ST_FLAGS,
    ST_CSUM,
    ST_DROP
  } state_t;

  localparam logic [15:0] MAX_CNT = 16'(MAX_BYTES);

  state_t      state_q, state_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic [7:0]  m_data_q, m_data_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  csum_q, csum_d;
  logic        trunc_q, trunc_d;
  logic        trunc_pulse_q, trunc_pulse_d;

  logic        load;
  logic        s_ready;
  logic        s_acc;
  logic        emit;
  logic        emit_last;
  logic [7:0]  emit_byte;
  logic [15:0] count_inc;

  // The output register may take a new byte when empty or when its byte is leaving.
  assign load      = !m_valid_q || m_axis.tready;
  assign s_ready   = (state_q == ST_BODY) ? load : (state_q == ST_DROP);
  assign s_acc     = s_axis.tvalid && s_ready;
  assign count_inc = count_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    m_valid_d     = m_valid_q;
    m_last_d      = m_last_q;
    m_data_d      = m_data_q;
    seq_d         = seq_q;
    count_d       = count_q;
    csum_d        = csum_q;
    trunc_d       = trunc_q;
    trunc_pulse_d = 1'b0;
    emit          = 1'b0;
    emit_last     = 1'b0;
    emit_byte     = 8'h00;

    // A consumed output byte with nothing new behind it empties the register.
    if (load) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (s_axis.tvalid) state_d = ST_SYNC0;
      end
      ST_SYNC0: begin
        if (load) begin
          emit      = 1'b1;
          emit_byte = SYNC0;
          state_d   = ST_SYNC1;
        end
      end
      ST_SYNC1: begin
        if (load) begin
          emit      = 1'b1;
          emit_byte = SYNC1;
          state_d   = ST_SEQLO;
        end
      end
      ST_SEQLO: begin
        if (load) begin
          emit      = 1'b1;
          emit_byte = seq_q[7:0];
          state_d   = ST_SEQHI;
        end
      end
      ST_SEQHI: begin
        if (load) begin
          emit      = 1'b1;
          emit_byte = seq_q[15:8];
          state_d   = ST_BODY;
        end
      end
      ST_BODY: begin
        if (s_acc) begin
          if (s_axis.tkeep) begin
            emit      = 1'b1;
            emit_byte = s_axis.tdata;
            count_d   = count_inc;
          end
          if (s_axis.tlast) begin
            state_d = ST_CNTLO;
          end else if (s_axis.tkeep && (count_inc == MAX_CNT)) begin
            // Frame hit the length bound before its tlast: close it and shed the rest.
            state_d       = ST_CNTLO;
            trunc_d       = 1'b1;
            trunc_pulse_d = 1'b1;
          end
        end
      end
      ST_CNTLO: begin
        if (load) begin
          emit      = 1'b1;
          emit_byte = count_q[7:0];
          state_d   = ST_CNTHI;
        end
      end
      ST_CNTHI: begin
        if (load) begin
          emit      = 1'b1;
          emit_byte = count_q[15:8];
          state_d   = ST_FLAGS;
        end
      end
      ST_FLAGS: begin
        if (load) begin
          emit      = 1'b1;
          emit_byte = {7'b0, trunc_q};
          state_d   = ST_CSUM;
        end
      end
      ST_CSUM: begin
        // The checksum byte is the only one carrying tlast, so valid&last marks it loaded.
        if (m_valid_q && m_last_q) begin
          if (m_axis.tready) begin
            seq_d   = seq_q + 16'd1;
            count_d = 16'd0;
            csum_d  = 8'h00;
            trunc_d = 1'b0;
            state_d = trunc_q ? ST_DROP : ST_IDLE;
          end
        end else if (load) begin
          emit      = 1'b1;
          emit_last = 1'b1;
          emit_byte = csum_q;
        end
      end
      ST_DROP: begin
        if (s_acc && s_axis.tlast) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (emit) begin
      m_valid_d = 1'b1;
      m_last_d  = emit_last;
      m_data_d  = emit_byte;
      if (!emit_last) csum_d = csum_q ^ emit_byte;
    end
  end

  always_ff @(posedge bus_clock or negedge areset_n) begin
    if (!areset_n) begin
      state_q       <= ST_IDLE;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      m_data_q      <= 8'h00;
      seq_q         <= 16'd0;
      count_q       <= 16'd0;
      csum_q        <= 8'h00;
      trunc_q       <= 1'b0;
      trunc_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      m_data_q      <= m_data_d;
      seq_q         <= seq_d;
      count_q       <= count_d;
      csum_q        <= csum_d;
      trunc_q       <= trunc_d;
      trunc_pulse_q <= trunc_pulse_d;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tkeep  = m_valid_q;
  assign m_axis.tlast  = m_last_q;
  assign m_axis.tdata  = m_data_q;
  assign seq_o         = seq_q;
  assign trunc_o       = trunc_pulse_q;

endmodule

// File: tb/tb_vis_framer.sv
// Directed bench for vis_framer (MAX_BYTES=4): packet layout, backpressure, truncation,
// null beats, empty frames, sequence wrap and asynchronous reset mid-packet.
module tb_vis_framer;

  logic        clk;
  logic        rst_n;
  logic [15:0] seq;
  logic        trunc;

  vis_framer_if s_if ();
  vis_framer_if m_if ();

  vis_framer #(.SYNC0(8'h5A), .SYNC1(8'hA5), .MAX_BYTES(4)) dut (
    .bus_clock (clk),
    .areset_n  (rst_n),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .seq_o     (seq),
    .trunc_o   (trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [7:0] rx_data[$];
  logic       rx_last[$];
  logic [7:0] exp_q[$];
  logic [7:0] up_data[$];
  logic       up_keep[$];
  logic [7:0] pl[$];
  int         pkt_cnt   = 0;
  int         trunc_cnt = 0;
  int         stall_err = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] held_data  = 8'h00;
  logic       up_acc     = 1'b0;
  logic       toggle_mode = 1'b0;

  always @(posedge clk) begin
    if (m_if.tvalid && m_if.tready) begin
      rx_data.push_back(m_if.tdata);
      rx_last.push_back(m_if.tlast);
      if (m_if.tlast) pkt_cnt <= pkt_cnt + 1;
    end
    if (stall_prev && (!m_if.tvalid || (m_if.tdata !== held_data))) stall_err <= stall_err + 1;
    stall_prev <= m_if.tvalid && !m_if.tready;
    held_data  <= m_if.tdata;
    if (trunc) trunc_cnt <= trunc_cnt + 1;
    up_acc <= s_if.tvalid && s_if.tready;
  end

  always @(negedge clk) m_if.tready = toggle_mode ? ~m_if.tready : 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_beat(input int i, input int n);
    s_if.tvalid = 1'b1;
    s_if.tdata  = up_data[i];
    s_if.tkeep  = up_keep[i];
    s_if.tlast  = (i == n - 1);
  endtask

  task automatic drive_frame();
    int n = up_data.size();
    int i = 0;
    int guard = 0;
    @(negedge clk);
    drive_beat(0, n);
    while (i < n && guard < 500) begin
      @(negedge clk);
      guard++;
      if (up_acc) i++;
      if (i < n) drive_beat(i, n);
      else s_if.tvalid = 1'b0;
    end
    if (i < n) begin
      chk("drive_timeout", i, n);
      s_if.tvalid = 1'b0;
    end
  endtask

  task automatic wait_pkt(input int target);
    int guard = 0;
    while (pkt_cnt < target && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (pkt_cnt < target) chk("pkt_timeout", pkt_cnt, target);
  endtask

  task automatic run_frame();
    int target = pkt_cnt + 1;
    rx_data.delete();
    rx_last.delete();
    fork
      drive_frame();
      wait_pkt(target);
    join
    repeat (3) @(negedge clk);
  endtask

  // Reference packet: header, payload in pl, count, flags, then XOR of all of it.
  task automatic build_exp(input logic [15:0] s, input logic [7:0] flags);
    logic [7:0] c;
    logic [15:0] n;
    n = 16'(pl.size());
    exp_q.delete();
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    exp_q.push_back(s[7:0]);
    exp_q.push_back(s[15:8]);
    foreach (pl[k]) exp_q.push_back(pl[k]);
    exp_q.push_back(n[7:0]);
    exp_q.push_back(n[15:8]);
    exp_q.push_back(flags);
    c = 8'h00;
    foreach (exp_q[k]) c = c ^ exp_q[k];
    exp_q.push_back(c);
  endtask

  task automatic compare_pkt(input string tag);
    chk({tag, "_len"}, rx_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), (i < rx_data.size()) ? rx_data[i] : 8'hxx, exp_q[i]);
      chk($sformatf("%s_l%0d", tag, i), (i < rx_last.size()) ? rx_last[i] : 1'bx,
          (i == exp_q.size() - 1));
    end
  endtask

  initial begin
    int tc;
    int pc;
    s_if.tvalid = 1'b0;
    s_if.tkeep  = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = 8'h00;
    m_if.tready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_m_tvalid", m_if.tvalid, 1'b0);
    chk("rst_m_tlast", m_if.tlast, 1'b0);
    chk("rst_m_tdata", m_if.tdata, 8'h00);
    chk("rst_s_tready", s_if.tready, 1'b0);
    chk("rst_seq", seq, 16'h0000);
    chk("rst_trunc", trunc, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: plain three-byte frame against a hand-written packet.
    up_data = '{8'h01, 8'h02, 8'h03};
    up_keep = '{1'b1, 1'b1, 1'b1};
    run_frame();
    exp_q = '{8'h5A, 8'hA5, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h03, 8'h00, 8'h00, 8'hFC};
    compare_pkt("t1");
    chk("t1_seq", seq, 16'h0001);

    // T2: same frame under alternating backpressure.
    toggle_mode = 1'b1;
    run_frame();
    toggle_mode = 1'b0;
    pl = '{8'h01, 8'h02, 8'h03};
    build_exp(16'h0001, 8'h00);
    compare_pkt("t2");
    chk("t2_stall_stable", stall_err, 0);
    chk("t2_seq", seq, 16'h0002);

    // T3: six-byte frame truncated at four, then a short follow-up frame.
    tc = trunc_cnt;
    pc = pkt_cnt;
    up_data = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    up_keep = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run_frame();
    pl = '{8'h10, 8'h11, 8'h12, 8'h13};
    build_exp(16'h0002, 8'h01);
    compare_pkt("t3");
    chk("t3_trunc_pulses", trunc_cnt - tc, 1);
    chk("t3_one_packet", pkt_cnt - pc, 1);
    up_data = '{8'h20};
    up_keep = '{1'b1};
    run_frame();
    pl = '{8'h20};
    build_exp(16'h0003, 8'h00);
    compare_pkt("t3_next");

    // Exactly MAX_BYTES with tlast on the last byte is a normal end.
    tc = trunc_cnt;
    up_data = '{8'h30, 8'h31, 8'h32, 8'h33};
    up_keep = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_frame();
    pl = '{8'h30, 8'h31, 8'h32, 8'h33};
    build_exp(16'h0004, 8'h00);
    compare_pkt("exact_max");
    chk("exact_no_trunc", trunc_cnt - tc, 0);

    // T4: null beat skipped, then an empty frame.
    up_data = '{8'hA0, 8'hB1};
    up_keep = '{1'b0, 1'b1};
    run_frame();
    pl = '{8'hB1};
    build_exp(16'h0005, 8'h00);
    compare_pkt("t4_null");
    up_data = '{8'hEE};
    up_keep = '{1'b0};
    run_frame();
    pl.delete();
    build_exp(16'h0006, 8'h00);
    compare_pkt("t4_empty");

    // T5: sequence number wrap.
    @(negedge clk);
    force dut.seq_q = 16'hFFFF;
    @(negedge clk);
    release dut.seq_q;
    @(negedge clk);
    chk("t5_seq_pre", seq, 16'hFFFF);
    up_data = '{8'h44};
    up_keep = '{1'b1};
    run_frame();
    pl = '{8'h44};
    build_exp(16'hFFFF, 8'h00);
    compare_pkt("t5");
    chk("t5_seq_wrap", seq, 16'h0000);

    // T6: reset while the body of the second frame is streaming.
    up_data = '{8'h55};
    up_keep = '{1'b1};
    run_frame();
    chk("t6_seq_before", seq, 16'h0001);
    @(negedge clk);
    s_if.tvalid = 1'b1;
    s_if.tkeep  = 1'b1;
    s_if.tlast  = 1'b0;
    s_if.tdata  = 8'h66;
    repeat (8) @(negedge clk);
    chk("t6_body_active", m_if.tvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", m_if.tvalid, 1'b0);
    chk("t6_rst_tdata", m_if.tdata, 8'h00);
    chk("t6_rst_seq", seq, 16'h0000);
    chk("t6_rst_tready", s_if.tready, 1'b0);
    s_if.tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    up_data = '{8'h77};
    up_keep = '{1'b1};
    run_frame();
    pl = '{8'h77};
    build_exp(16'h0000, 8'h00);
    compare_pkt("t6_after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
